backscatter_bit_scheduler: RTL and testbench
============================================

BACKSCATTER_BIT_SCHEDULER -- requirements
Module: backscatter_bit_scheduler

Interface
REQ-001 SHALL have parameters, one per line: DIV_W, 12, symbol-divider width; DATA_W, 32, payload word width; PRE_BITS, 8, preamble length in bits.
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port div_cfg  input  DIV_W  symbol period minus one, in clock cycles.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-006 SHALL have ports word_valid input 1, word_data input DATA_W, word_last input 1; these form the payload source.
REQ-007 SHALL have port word_ready  output  1  single-cycle word accept strobe.
REQ-008 SHALL have port sym_out  output  1  current backscatter symbol level.
REQ-009 SHALL have port sym_tick  output  1  one-cycle pulse in the first cycle of each symbol.
REQ-010 SHALL have ports busy, done, underrun, all output, 1 bit: frame active, one-cycle completion pulse, one-cycle abort pulse.

Function
REQ-011 SHALL implement states IDLE, PRE, DATA, and DONE.
REQ-012 In IDLE, start=1 SHALL latch div_cfg into an internal period register, clear the divider, and enter PRE on the next edge; start outside IDLE SHALL be ignored.
REQ-013 Symbol boundary SHALL occur when the divider equals the latched period; the divider then wraps to 0, otherwise it increments by 1.
REQ-014 Each symbol SHALL last exactly period+1 cycles; period=0 SHALL give one-cycle symbols.
REQ-015 The first PRE symbol SHALL appear on sym_out in the cycle after start is sampled, with sym_tick=1 and busy=1.
REQ-016 PRE SHALL emit PRE_BITS symbols alternating 1,0,1,0,..., starting with 1.
REQ-017 word_ready SHALL be 1 only in the boundary cycle that ends the last PRE symbol, or the last bit of a DATA word whose word_last was 0.
REQ-018 A word SHALL transfer when word_valid&word_ready; word_data and word_last are then captured, and bit 0 is emitted next.
REQ-019 DATA words SHALL be shifted out LSB first, one bit per symbol, DATA_W symbols per word.
REQ-020 If word_valid=0 while word_ready=1, the block SHALL pulse underrun, drive sym_out=0, and return to IDLE on the next edge with no done pulse.
REQ-021 After the last bit of a word captured with word_last=1, the block SHALL enter DONE for one cycle, pulse done, deassert busy, and drive sym_out=0, then go to IDLE.
REQ-022 start sampled in the DONE cycle SHALL be ignored; start in the cycle after DONE SHALL be accepted.
REQ-023 div_cfg changes during a frame SHALL have no effect until the next start.
REQ-024 In IDLE, sym_out, sym_tick, busy, and word_ready SHALL be 0.

Reset
REQ-025 Reset assertion SHALL immediately force state IDLE, divider 0, period 0, shift register 0, and all outputs 0, including mid-frame.
REQ-026 After reset release, the first accepted start SHALL behave identically to a post-DONE start.

Configuration
REQ-027 With macro BACKSCATTER_WHITENING_EN defined, DATA bits SHALL be XORed with a 7-bit LFSR (x^7+x^4+1), seeded 7'h53 at start and advanced once per DATA symbol; PRE bits SHALL be unwhitened.
REQ-028 Without BACKSCATTER_WHITENING_EN, DATA bits SHALL be emitted raw, and no LFSR logic SHALL exist.

Verification
REQ-029 Bench SHALL cover: div_cfg=15, start, one word 32'h0000_0001 with last=1 -> 8 PRE symbols of 16 cycles, then 1 followed by 31 zeros, done at cycle 1+40*16.
REQ-030 Bench SHALL cover: div_cfg=0, two words 32'hFFFF_0000 (last=0) then 32'h0000_FFFF (last=1) -> 64 data symbols of 1 cycle each, and exactly two word_ready pulses.
REQ-031 Bench SHALL cover: word_valid held 0 at the first word_ready -> underrun pulse, busy=0 next cycle, no done.
REQ-032 Bench SHALL cover: reset asserted mid-DATA -> all outputs 0 asynchronously, and a new start after release restarts PRE.
REQ-033 Bench SHALL cover: div_cfg changed from 3 to 7 mid-frame, and start pulsed during DATA -> symbol length stays 4 cycles and the frame is unaffected.
REQ-034 Bench SHALL cover: with BACKSCATTER_WHITENING_EN, payload 32'h0 -> sym_out matches the LFSR sequence from seed 7'h53.

Source files
------------

// File: rtl/backscatter_bit_scheduler.sv
// ---------------------------------------------------------------------------
// backscatter_bit_scheduler
//
// Purpose: frames a backscatter transmission. On start it emits an
// alternating 1/0 preamble, then pulls payload words from a valid/ready
// source and shifts them out LSB first, one bit per symbol. Every symbol
// lasts (period + 1) clock cycles. The period is captured from div_cfg
// when the frame starts.
//
// Optional feature: define BACKSCATTER_WHITENING_EN to XOR the payload bits
// with a 7-bit LFSR (x^7 + x^4 + 1, seed 7'h53). The LFSR is reloaded at
// start and advances once per payload symbol. Preamble bits are never
// whitened.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   div_cfg     symbol period minus one, in clock cycles
//   start       single-cycle frame request (only accepted in IDLE)
//   word_valid  payload word available
//   word_data   payload word
//   word_last   payload word is the last of the frame
//   word_ready  single-cycle word accept strobe
//   sym_out     current symbol level
//   sym_tick    pulse in the first cycle of each symbol
//   busy        frame in progress (PRE or DATA)
//   done        one-cycle pulse on normal frame completion
//   underrun    one-cycle pulse when no word was available at word_ready
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start; all outputs low
// PRE   | emitting PRE_BITS alternating preamble symbols
// DATA  | emitting payload bits, LSB first
// DONE  | one-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
module backscatter_bit_scheduler #(
    parameter int DIV_W    = 12,
    parameter int DATA_W   = 32,
    parameter int PRE_BITS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div_cfg,
    input  logic              start,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              sym_out,
    output logic              sym_tick,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int CNT_MAX = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
    localparam int IDX_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_BITS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  period;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              last_flag;
    logic              white_bit;

    logic boundary;
    logic pre_end;
    logic data_end;
    logic want_word;
    logic xfer;

    assign boundary  = (div == period);
    assign pre_end   = (state == S_PRE)  && boundary && (idx == PRE_LAST);
    assign data_end  = (state == S_DATA) && boundary && (idx == DATA_LAST);
    // A new word is requested after the preamble, and after each word that
    // was not marked last.
    assign want_word = pre_end || (data_end && !last_flag);
    assign xfer      = want_word && word_valid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PRE;
                end
            end
            S_PRE: begin
                if (pre_end) begin
                    state_next = word_valid ? S_DATA : S_IDLE;
                end
            end
            S_DATA: begin
                if (data_end) begin
                    if (last_flag) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = word_valid ? S_DATA : S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        word_ready = 1'b0;
        sym_out    = 1'b0;
        sym_tick   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        underrun   = 1'b0;
        case (state)
            S_PRE: begin
                busy       = 1'b1;
                sym_tick   = (div == '0);
                sym_out    = ~idx[0];
                word_ready = want_word;
            end
            S_DATA: begin
                busy       = 1'b1;
                sym_tick   = (div == '0);
                sym_out    = shreg[0] ^ white_bit;
                word_ready = want_word;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        // Abort cycle: the source had nothing to give, so the carrier is
        // parked low while the block drops back to IDLE.
        if (want_word && !word_valid) begin
            underrun = 1'b1;
            sym_out  = 1'b0;
        end
    end

    // Symbol timing, bit counting and payload shifting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            period    <= '0;
            idx       <= '0;
            shreg     <= '0;
            last_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div <= '0;
                    idx <= '0;
                    if (start) begin
                        period <= div_cfg;
                    end
                end
                S_PRE, S_DATA: begin
                    div <= boundary ? '0 : div + 1'b1;
                    if (boundary) begin
                        idx <= (pre_end || data_end) ? '0 : idx + 1'b1;
                    end
                    if (xfer) begin
                        shreg     <= word_data;
                        last_flag <= word_last;
                    end else if (boundary && (state == S_DATA)) begin
                        shreg <= shreg >> 1;
                    end
                end
                default: begin
                    div <= '0;
                end
            endcase
        end
    end

`ifdef BACKSCATTER_WHITENING_EN
    logic [6:0] lfsr;

    // Fibonacci LFSR, taps at bits 7 and 4; the MSB is the whitening bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 7'h53;
        end else if ((state == S_IDLE) && start) begin
            lfsr <= 7'h53;
        end else if ((state == S_DATA) && boundary) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
        end
    end

    assign white_bit = lfsr[6];
`else
    assign white_bit = 1'b0;
`endif

endmodule

// File: tb/tb_backscatter_bit_scheduler.sv
`timescale 1ns/1ps
module tb_backscatter_bit_scheduler;

    localparam int DIV_W    = 12;
    localparam int DATA_W   = 32;
    localparam int PRE_BITS = 8;
`ifdef BACKSCATTER_WHITENING_EN
    localparam bit WHITEN = 1'b1;
`else
    localparam bit WHITEN = 1'b0;
`endif
    localparam int EV_DONE = 1;   // {underrun, done}
    localparam int EV_UR   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [DIV_W-1:0]  div_cfg = '0;
    logic              start = 1'b0;
    logic              word_valid = 1'b0;
    logic [DATA_W-1:0] word_data = '0;
    logic              word_last = 1'b0;
    logic              word_ready, sym_out, sym_tick, busy, done, underrun;

    backscatter_bit_scheduler #(.DIV_W(DIV_W), .DATA_W(DATA_W), .PRE_BITS(PRE_BITS)) dut (
        .clock(clock), .reset(reset), .div_cfg(div_cfg), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .sym_out(sym_out), .sym_tick(sym_tick),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic lvl; int len; } sym_t;
    typedef struct { int kind; int at; } evt_t;
    typedef struct { logic [DATA_W-1:0] data; logic last; } word_t;

    sym_t  exp_sym[$];
    evt_t  exp_evt[$];
    word_t src_q[$];

    int tests = 0;
    int fails = 0;
    int ready_cnt = 0;
    int rc0, exp_ready, end_cyc, frame_start;
    logic [DATA_W-1:0] fw[4];
    logic wseq[0:4*DATA_W-1];

    function automatic void chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic wbit(input int k);
        return wseq[k] & WHITEN;
    endfunction

    function automatic void refresh_src();
        word_valid = (src_q.size() > 0);
        word_data  = word_valid ? src_q[0].data : '0;
        word_last  = word_valid ? src_q[0].last : 1'b0;
    endfunction

    // Payload source: presents the queue head; pops after an accepted transfer.
    initial begin
        logic xs;
        forever begin
            @(negedge clock);
            xs = reset && word_ready && word_valid;
            @(posedge clock);
            #1;
            if (xs && src_q.size() > 0) void'(src_q.pop_front());
            refresh_src();
        end
    end

    // Monitor: pops expected symbols on sym_tick, events on done/underrun.
    initial begin
        logic open_sym = 1'b0;
        logic cur_lvl = 1'b0;
        int   cur_len = 0;
        int   run_len = 0;
        logic prev_ur = 1'b0;
        sym_t s;
        evt_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                open_sym = 1'b0;
                prev_ur  = 1'b0;
            end else begin
                if (prev_ur) chk("busy_after_underrun", busy, 0);
                prev_ur = underrun;
                if (busy) begin
                    if (sym_tick) begin
                        if (open_sym) chk("sym_len", run_len, cur_len);
                        if (exp_sym.size() == 0) begin
                            chk("unexpected_symbol", 1, 0);
                            open_sym = 1'b0;
                        end else begin
                            s = exp_sym.pop_front();
                            cur_lvl = s.lvl;
                            cur_len = s.len;
                            run_len = 0;
                            open_sym = 1'b1;
                        end
                    end else if (!open_sym) begin
                        chk("busy_without_symbol", 1, 0);
                    end
                    run_len++;
                    if (underrun) chk("sym_out_at_underrun", sym_out, 0);
                    else if (open_sym) chk("sym_level", sym_out, cur_lvl);
                end else begin
                    if (open_sym) begin
                        chk("sym_len", run_len, cur_len);
                        open_sym = 1'b0;
                    end
                    chk("idle_outputs", {sym_out, sym_tick, word_ready, underrun}, 0);
                end
                if (word_ready) ready_cnt++;
                if (underrun || done) begin
                    if (exp_evt.size() == 0) begin
                        chk("unexpected_event", 1, 0);
                    end else begin
                        e = exp_evt.pop_front();
                        chk("event_kind", {underrun, done}, e.kind);
                        chk("event_cycle", cyc, e.at);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Queues the expected response of one frame, then pulses start.
    task automatic start_frame(input int p, input int nw, input bit ur);
        sym_t  s;
        word_t w;
        evt_t  e;
        int    k = 0;
        int    nsym = PRE_BITS + nw * DATA_W;
        frame_start = cyc;
        for (int i = 0; i < PRE_BITS; i++) begin
            s.lvl = (i % 2 == 0);
            s.len = p + 1;
            exp_sym.push_back(s);
        end
        for (int wi = 0; wi < nw; wi++) begin
            w.data = fw[wi];
            w.last = !ur && (wi == nw - 1);
            src_q.push_back(w);
            for (int b = 0; b < DATA_W; b++) begin
                s.lvl = fw[wi][b] ^ wbit(k);
                s.len = p + 1;
                exp_sym.push_back(s);
                k++;
            end
        end
        e.kind = ur ? EV_UR : EV_DONE;
        e.at   = frame_start + nsym * (p + 1) + (ur ? 0 : 1);
        exp_evt.push_back(e);
        end_cyc   = e.at;
        exp_ready = ur ? nw + 1 : nw;
        rc0       = ready_cnt;
        refresh_src();
        div_cfg = DIV_W'(p);
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        wait_until(end_cyc + 2);
        chk({name, "_ready_pulses"}, ready_cnt - rc0, exp_ready);
        chk({name, "_leftover_symbols"}, exp_sym.size(), 0);
        chk({name, "_leftover_events"}, exp_evt.size(), 0);
        chk({name, "_leftover_words"}, src_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seed;
        int p, nw;
        bit ur;
        seed = 7'h53;
        for (int i = 0; i < 7; i++) wseq[i] = seed[6 - i];
        for (int i = 7; i < 4 * DATA_W; i++) wseq[i] = wseq[i - 7] ^ wseq[i - 4];

        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {busy, sym_out, sym_tick, word_ready, done, underrun}, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Slow symbols, single word with one set bit.
        fw[0] = 32'h0000_0001;
        start_frame(15, 1, 1'b0);
        chk("done_offset", end_cyc - frame_start, 1 + 40 * 16);
        finish_frame("slow_single");

        // One-cycle symbols, two words.
        fw[0] = 32'hFFFF_0000;
        fw[1] = 32'h0000_FFFF;
        start_frame(0, 2, 1'b0);
        finish_frame("fast_two_words");

        // No word available at the first request.
        start_frame(2, 0, 1'b1);
        finish_frame("underrun_first");

        // Asynchronous reset in the middle of DATA.
        fw[0] = $urandom;
        start_frame(2, 1, 1'b0);
        wait_until(end_cyc - 40);
        chk("busy_before_reset", busy, 1);
        #1 reset = 1'b0;
        #1 chk("async_reset_outputs", {busy, sym_out, sym_tick, word_ready, done, underrun}, 0);
        exp_sym.delete();
        exp_evt.delete();
        src_q.delete();
        refresh_src();
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        fw[0] = $urandom;
        start_frame(1, 1, 1'b0);
        finish_frame("after_reset");

        // div_cfg change and a stray start while the frame runs.
        fw[0] = $urandom;
        start_frame(3, 1, 1'b0);
        wait_until(frame_start + 10);
        div_cfg = DIV_W'(7);
        wait_until(frame_start + PRE_BITS * 4 + 20);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        finish_frame("midframe_changes");

        // start in the DONE cycle is dropped; start one cycle later is taken.
        fw[0] = $urandom;
        start_frame(1, 1, 1'b0);
        wait_until(end_cyc);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("first_ready_pulses", ready_cnt - rc0, exp_ready);
        fw[0] = $urandom;
        fw[1] = $urandom;
        start_frame(2, 2, 1'b0);
        finish_frame("start_after_done");

        // All-zero payload exposes the whitening sequence when enabled.
        fw[0] = 32'h0;
        start_frame(1, 1, 1'b0);
        finish_frame("zero_payload");

        // Randomized frames, some ending in underrun.
        for (int it = 0; it < 8; it++) begin
            p  = $urandom_range(0, 4);
            ur = ($urandom_range(0, 3) == 0);
            nw = ur ? $urandom_range(0, 2) : $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) fw[i] = $urandom;
            start_frame(p, nw, ur);
            finish_frame("random");
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
